mem_arbiter: RTL

- Two-requester arbiter/sequencer in front of the single-port 16-bit RAM (combinational read, write on posedge clk).
- Port 0 is the processor; port 1 is the I/O/loader path.
- Serialises accesses, grants round-robin (or fixed priority), drives the RAM's addr/data/we, and returns registered read data with a one-cycle ack per transaction.

---
 rtl/mem_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of a single-port RAM.
// One transaction per IDLE -> ACCESS -> RESP pass; registered read data and one-cycle ack.
module mem_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int FIXED_PRIO = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  ack0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_q,
   output logic                  busy
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;
   logic [1:0]            state;
   logic                  lat_we;
   logic                  lat_id;
   logic                  last;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic                  win;
   // On a tie, round-robin picks the port not served last; the pointer is still tracked under fixed priority.
   always_comb win = (req0 && req1) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last) : req1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_we    <= 1'b0;
         lat_id    <= 1'b0;
         last      <= 1'b1;
         lat_addr  <= '0;
         lat_wdata <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: if (req0 || req1) begin
               state     <= ACCESS;
               lat_id    <= win;
               last      <= win;
               lat_we    <= win ? we1 : we0;
               lat_addr  <= win ? addr1 : addr0;
               lat_wdata <= win ? wdata1 : wdata0;
            end
            ACCESS: begin
               state <= RESP;
               if (lat_id) begin
                  ack1   <= 1'b1;
                  rdata1 <= mem_q;
               end else begin
                  ack0   <= 1'b1;
                  rdata0 <= mem_q;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign mem_addr = lat_addr;
   assign mem_data = lat_wdata;
   assign mem_we   = (state == ACCESS) && lat_we;
   assign busy     = (state == ACCESS) || (state == RESP);
endmodule
